// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: paces one-cycle start pulses to the SPI sine DAC at a
// programmable period, waits for each transfer's end pulse, counts completed
// samples and flags overrun (transfer longer than the period) and timeout.
module dac_sample_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 12,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [CNT_W-1:0]    burst_i,
  input  logic                end_i,
  output logic                start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                ovr_o,
  output logic                tout_o,
  output logic [CNT_W-1:0]    cnt_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int TC_W = ((PERIOD_W + 1) > TO_W) ? (PERIOD_W + 1) : TO_W;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT, S_GAP} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_period;
  logic [CNT_W-1:0]    r_burst;
  logic [CNT_W-1:0]    r_cnt;
  logic [TC_W-1:0]     r_tc;
  logic                r_start;
  logic                r_busy;
  logic                r_done;
  logic                r_ovr;
  logic                r_tout;

  logic [PERIOD_W-1:0] w_period;
  logic [TC_W-1:0]     w_tc_last;
  logic [TC_W-1:0]     w_tc_inc;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_burst_hit;
  logic                w_tout_hit;
  logic                w_overrun;

  // Period clamp, cycle-count thresholds and burst completion for the current sample
  always_comb begin
    w_period    = (period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : period_i;
    w_tc_last   = TC_W'(r_period) - TC_W'(1);
    w_tc_inc    = r_tc + TC_W'(1);
    w_cnt_inc   = r_cnt + CNT_W'(1);
    w_burst_hit = (r_burst != '0) && (w_cnt_inc == r_burst);
    w_tout_hit  = (r_tc == TC_W'(TIMEOUT - 1));
    w_overrun   = (r_tc >= w_tc_last);
  end

  // Sequencer: IDLE -> FIRE -> WAIT -> (GAP -> FIRE | IDLE), all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
      r_tc     <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en_i) begin
            r_period <= w_period;
            r_burst  <= burst_i;
            r_cnt    <= '0;
            r_ovr    <= 1'b0;
            r_tout   <= 1'b0;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_tc    <= TC_W'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_tc <= w_tc_inc;
          // end_i wins over the timeout on the same edge; burst completion wins over disable
          if (end_i) begin
            r_cnt <= w_cnt_inc;
            if (w_burst_hit) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (!en_i) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (w_overrun) begin
              r_ovr   <= 1'b1;
              r_start <= 1'b1;
              r_state <= S_FIRE;
            end else begin
              r_state <= S_GAP;
            end
          end else if (w_tout_hit) begin
            r_tout  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          r_tc <= w_tc_inc;
          if (!en_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tc == w_tc_last) begin
            r_start <= 1'b1;
            r_state <= S_FIRE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start_o = r_start;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign ovr_o   = r_ovr;
  assign tout_o  = r_tout;
  assign cnt_o   = r_cnt;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler. A DAC responder answers each start_o with an
// end_i pulse a chosen number of cycles later; a per-sample arithmetic model
// predicts start cycles, done cycles, final count and sticky flags.
`timescale 1ns/1ps
module tb_dac_sample_scheduler;
  localparam int PW = 16;
  localparam int CW = 12;
  localparam int TO = 20;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          end_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic [CW-1:0] burst_i = '0;
  logic          start_o, busy_o, done_o, ovr_o, tout_o;
  logic [CW-1:0] cnt_o;

  dac_sample_scheduler #(.PERIOD_W(PW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .period_i(period_i),
    .burst_i(burst_i), .end_i(end_i), .start_o(start_o), .busy_o(busy_o),
    .done_o(done_o), .ovr_o(ovr_o), .tout_o(tout_o), .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  int dly[$];          // per-sample end delay (cycles after start_o); -1 = never
  int dq[$];           // responder copy of dly
  int end_sched[$];    // cycles in which end_i is driven high
  int spur_off[$];     // spurious end_i offsets relative to first start
  int spur[$];
  int obs_starts[$];
  int obs_done[$];
  int obs_tout = -1;
  int scen_s0 = 0;
  int exp_starts[$];
  int exp_done[$];
  int exp_cnt = 0;
  bit exp_ovr = 1'b0;
  int exp_tout_cyc = -1;
  int en_off = -1;
  int t_end = 0;

  // One cycle: sample outputs at negedge, answer start_o, drive end_i / en_i
  task automatic step();
    int e;
    int d;
    @(negedge clk_i);
    if (cyc >= scen_s0) begin
      if (start_o) begin
        obs_starts.push_back(cyc);
        if (dq.size() > 0) begin
          d = dq.pop_front();
          if (d >= 0) end_sched.push_back(cyc + d);
        end
      end
      if (done_o) obs_done.push_back(cyc);
      if (tout_o && obs_tout < 0) obs_tout = cyc;
    end
    e = 0;
    foreach (end_sched[i]) if (end_sched[i] == cyc) e = 1;
    foreach (spur[i]) if (spur[i] == cyc) e = 1;
    end_i = (e != 0);
    if (cyc == en_off) en_i = 1'b0;
  endtask

  // Per-sample model: next start = start + P, or start + d + 1 when the DAC overruns
  task automatic model(input int s0, input int p, input int burst, input int runs,
                       input int drop_k, input int drop_off);
    int s, cnt, i, d, run;
    bit fin;
    exp_starts.delete(); exp_done.delete();
    exp_ovr = 1'b0; exp_tout_cyc = -1; en_off = -1;
    s = s0; cnt = 0; i = 0; run = 0; fin = 1'b0;
    while (!fin) begin
      exp_starts.push_back(s);
      d = (i < dly.size()) ? dly[i] : -1;
      if (i == drop_k) en_off = s + drop_off;
      if (d < 0 || d >= TO) begin
        exp_tout_cyc = s + TO;
        if (en_off < 0) en_off = s + TO;
        t_end = s + TO;
        fin = 1'b1;
      end else begin
        cnt = (cnt + 1) % (1 << CW);
        if (burst != 0 && cnt == burst) begin
          exp_done.push_back(s + d + 1);
          run++;
          if (run == runs) begin
            if (en_off < 0) en_off = s + d + 1;
            t_end = s + d + 1;
            fin = 1'b1;
          end else begin
            s = s + d + 2;
            cnt = 0;
            exp_ovr = 1'b0;
          end
        end else if (i == drop_k) begin
          t_end = s + d + 1;
          fin = 1'b1;
        end else if (d >= p - 1) begin
          exp_ovr = 1'b1;
          s = s + d + 1;
        end else begin
          s = s + p;
        end
      end
      i++;
    end
    exp_cnt = cnt;
  endtask

  task automatic run_scenario(input int p_in, input int burst, input int runs,
                              input int drop_k, input int drop_off);
    int s0, pe, lim;
    step();
    period_i = PW'(p_in);
    burst_i  = CW'(burst);
    s0 = cyc + 1;
    pe = (p_in < 2) ? 2 : p_in;
    model(s0, pe, burst, runs, drop_k, drop_off);
    spur.delete();
    foreach (spur_off[k]) spur.push_back(s0 + spur_off[k]);
    scen_s0 = s0; dq = dly; end_sched.delete();
    obs_starts.delete(); obs_done.delete(); obs_tout = -1;
    en_i = 1'b1;
    lim = t_end + 4;
    while (cyc < lim) step();
    spur.delete();
  endtask

  task automatic test_reset();
    en_i = 1'b1; period_i = 16'd7; burst_i = 12'd3;
    repeat (3) step();
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (ovr_o !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", ovr_o); end
    total++; if (tout_o !== 1'b0) begin bad++; $display("FAIL reset_tout: got %b want 0", tout_o); end
    total++; if (cnt_o !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_o); end
    en_i = 1'b0;
    step();
    rst_i = 1'b0;
    repeat (2) step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_burst();
    int p, b;
    for (int it = 0; it < 5; it++) begin
      dly.delete(); spur_off.delete();
      if (it == 0) begin
        p = 10; b = 3; repeat (3) dly.push_back(4);
      end else begin
        p = $urandom_range(3, 12); b = $urandom_range(1, 5);
        repeat (b) dly.push_back($urandom_range(1, p - 2));
      end
      run_scenario(p, b, 1, -1, 0);
      total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL burst_nstarts it%0d: got %0d want %0d", it, obs_starts.size(), exp_starts.size()); end
      foreach (exp_starts[k]) if (k < obs_starts.size()) begin
        total++; if (obs_starts[k] !== exp_starts[k]) begin bad++; $display("FAIL burst_start[%0d] it%0d: got cyc %0d want cyc %0d", k, it, obs_starts[k], exp_starts[k]); end
      end
      total++; if (obs_done.size() !== 1 || obs_done[0] !== exp_done[0]) begin bad++; $display("FAIL burst_done it%0d: got %0d pulses first %0d want 1 at %0d", it, obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done[0]); end
      total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL burst_cnt it%0d: got %0d want %0d", it, cnt_o, exp_cnt); end
      total++; if (ovr_o !== exp_ovr) begin bad++; $display("FAIL burst_ovr it%0d: got %b want %b", it, ovr_o, exp_ovr); end
      total++; if (tout_o !== 1'b0) begin bad++; $display("FAIL burst_tout it%0d: got %b want 0", it, tout_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL burst_busy it%0d: got %b want 0", it, busy_o); end
    end
  endtask

  task automatic test_overrun();
    int p, n, d;
    for (int it = 0; it < 4; it++) begin
      dly.delete(); spur_off.delete();
      if (it == 0) begin
        p = 5; n = 4; repeat (4) dly.push_back(7);
      end else begin
        p = $urandom_range(2, 10); n = $urandom_range(3, 6);
        repeat (n) dly.push_back($urandom_range(1, 15));
      end
      d = dly[n - 1];
      run_scenario(p, 0, 1, n - 1, $urandom_range(1, d));
      total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL ovr_nstarts it%0d: got %0d want %0d", it, obs_starts.size(), exp_starts.size()); end
      foreach (exp_starts[k]) if (k < obs_starts.size()) begin
        total++; if (obs_starts[k] !== exp_starts[k]) begin bad++; $display("FAIL ovr_start[%0d] it%0d: got cyc %0d want cyc %0d", k, it, obs_starts[k], exp_starts[k]); end
      end
      total++; if (ovr_o !== exp_ovr) begin bad++; $display("FAIL ovr_flag it%0d: got %b want %b", it, ovr_o, exp_ovr); end
      total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL ovr_cnt it%0d: got %0d want %0d", it, cnt_o, exp_cnt); end
      total++; if (obs_done.size() !== 0) begin bad++; $display("FAIL ovr_done it%0d: got %0d pulses want 0", it, obs_done.size()); end
    end
  endtask

  task automatic test_disable();
    int p, b, k, off;
    for (int it = 0; it < 5; it++) begin
      dly.delete(); spur_off.delete(); p = 8; b = 0;
      case (it)
        0: begin dly = '{2, 3}; k = 1; off = 3; end
        1: begin dly = '{2, 5, 3}; k = 1; off = 1; end
        2: begin dly = '{2, 4}; b = 2; k = 1; off = 4; end
        default: begin
          p = $urandom_range(3, 10);
          repeat (4) dly.push_back($urandom_range(1, 12));
          k = $urandom_range(0, 3); off = $urandom_range(1, dly[k]);
        end
      endcase
      run_scenario(p, b, 1, k, off);
      total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL dis_nstarts it%0d: got %0d want %0d", it, obs_starts.size(), exp_starts.size()); end
      foreach (exp_starts[j]) if (j < obs_starts.size()) begin
        total++; if (obs_starts[j] !== exp_starts[j]) begin bad++; $display("FAIL dis_start[%0d] it%0d: got cyc %0d want cyc %0d", j, it, obs_starts[j], exp_starts[j]); end
      end
      total++; if (obs_done.size() !== exp_done.size()) begin bad++; $display("FAIL dis_done it%0d: got %0d pulses want %0d", it, obs_done.size(), exp_done.size()); end
      total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL dis_cnt it%0d: got %0d want %0d", it, cnt_o, exp_cnt); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL dis_busy it%0d: got %b want 0", it, busy_o); end
      total++; if (ovr_o !== exp_ovr) begin bad++; $display("FAIL dis_ovr it%0d: got %b want %b", it, ovr_o, exp_ovr); end
    end
  endtask

  task automatic test_timeout();
    for (int it = 0; it < 3; it++) begin
      dly.delete(); spur_off.delete();
      case (it)
        0: dly = '{3, -1};
        1: dly = '{TO - 1, -1};
        default: dly = '{TO};
      endcase
      run_scenario(6, 0, 1, -1, 0);
      total++; if (obs_tout !== exp_tout_cyc) begin bad++; $display("FAIL tout_cycle it%0d: got cyc %0d want cyc %0d", it, obs_tout, exp_tout_cyc); end
      total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL tout_nstarts it%0d: got %0d want %0d", it, obs_starts.size(), exp_starts.size()); end
      foreach (exp_starts[j]) if (j < obs_starts.size()) begin
        total++; if (obs_starts[j] !== exp_starts[j]) begin bad++; $display("FAIL tout_start[%0d] it%0d: got cyc %0d want cyc %0d", j, it, obs_starts[j], exp_starts[j]); end
      end
      total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL tout_cnt it%0d: got %0d want %0d", it, cnt_o, exp_cnt); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL tout_busy it%0d: got %b want 0", it, busy_o); end
      total++; if (obs_done.size() !== 0) begin bad++; $display("FAIL tout_done it%0d: got %0d pulses want 0", it, obs_done.size()); end
    end
  endtask

  task automatic test_spurious();
    dly.delete(); dly = '{3, 3, 3};
    spur_off.delete(); spur_off = '{0, 5, 9, 15, 23};
    run_scenario(9, 3, 1, -1, 0);
    spur_off.delete();
    total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL spur_nstarts: got %0d want %0d", obs_starts.size(), exp_starts.size()); end
    foreach (exp_starts[j]) if (j < obs_starts.size()) begin
      total++; if (obs_starts[j] !== exp_starts[j]) begin bad++; $display("FAIL spur_start[%0d]: got cyc %0d want cyc %0d", j, obs_starts[j], exp_starts[j]); end
    end
    total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL spur_cnt: got %0d want %0d", cnt_o, exp_cnt); end
    total++; if (obs_done.size() !== 1 || obs_done[0] !== exp_done[0]) begin bad++; $display("FAIL spur_done: got %0d pulses want 1 at %0d", obs_done.size(), exp_done[0]); end
  endtask

  task automatic test_clamp();
    int pins[4] = '{0, 1, 2, 3};
    for (int it = 0; it < 4; it++) begin
      dly.delete(); spur_off.delete();
      repeat (4) dly.push_back(1);
      run_scenario(pins[it], 4, 1, -1, 0);
      total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL clamp_nstarts p%0d: got %0d want %0d", pins[it], obs_starts.size(), exp_starts.size()); end
      foreach (exp_starts[j]) if (j < obs_starts.size()) begin
        total++; if (obs_starts[j] !== exp_starts[j]) begin bad++; $display("FAIL clamp_start[%0d] p%0d: got cyc %0d want cyc %0d", j, pins[it], obs_starts[j], exp_starts[j]); end
      end
      total++; if (ovr_o !== exp_ovr) begin bad++; $display("FAIL clamp_ovr p%0d: got %b want %b", pins[it], ovr_o, exp_ovr); end
      total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL clamp_cnt p%0d: got %0d want %0d", pins[it], cnt_o, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int p;
    for (int it = 0; it < 3; it++) begin
      dly.delete(); spur_off.delete();
      p = $urandom_range(4, 8);
      repeat (6) dly.push_back($urandom_range(1, p + 3));
      run_scenario(p, 2, 3, -1, 0);
      total++; if (obs_starts.size() !== exp_starts.size()) begin bad++; $display("FAIL b2b_nstarts it%0d: got %0d want %0d", it, obs_starts.size(), exp_starts.size()); end
      foreach (exp_starts[j]) if (j < obs_starts.size()) begin
        total++; if (obs_starts[j] !== exp_starts[j]) begin bad++; $display("FAIL b2b_start[%0d] it%0d: got cyc %0d want cyc %0d", j, it, obs_starts[j], exp_starts[j]); end
      end
      total++; if (obs_done.size() !== exp_done.size()) begin bad++; $display("FAIL b2b_ndone it%0d: got %0d want %0d", it, obs_done.size(), exp_done.size()); end
      foreach (exp_done[j]) if (j < obs_done.size()) begin
        total++; if (obs_done[j] !== exp_done[j]) begin bad++; $display("FAIL b2b_done[%0d] it%0d: got cyc %0d want cyc %0d", j, it, obs_done[j], exp_done[j]); end
      end
      total++; if (cnt_o !== CW'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt it%0d: got %0d want %0d", it, cnt_o, exp_cnt); end
      total++; if (ovr_o !== exp_ovr) begin bad++; $display("FAIL b2b_ovr it%0d: got %b want %b", it, ovr_o, exp_ovr); end
    end
  endtask

  task automatic test_reset_mid();
    int r, nst;
    dly.delete(); repeat (12) dly.push_back(3);
    spur_off.delete(); spur.delete();
    step();
    period_i = 16'd4; burst_i = '0;
    model(cyc + 1, 4, 0, 1, -1, 0);
    scen_s0 = cyc + 1; dq = dly; end_sched.delete();
    obs_starts.delete(); obs_done.delete(); obs_tout = -1; en_off = -1;
    en_i = 1'b1;
    while (cyc < exp_starts[5] + 1) step();
    total++; if (cnt_o !== 12'd5) begin bad++; $display("FAIL rmid_pre_cnt: got %0d want 5", cnt_o); end
    total++; if (ovr_o !== 1'b1) begin bad++; $display("FAIL rmid_pre_ovr: got %b want 1", ovr_o); end
    rst_i = 1'b1; dq.delete(); end_sched.delete();
    step();
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL rmid_start: got %b want 0", start_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", done_o); end
    total++; if (ovr_o !== 1'b0) begin bad++; $display("FAIL rmid_ovr: got %b want 0", ovr_o); end
    total++; if (tout_o !== 1'b0) begin bad++; $display("FAIL rmid_tout: got %b want 0", tout_o); end
    total++; if (cnt_o !== '0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", cnt_o); end
    step();
    nst = obs_starts.size();
    dq.push_back(2);
    rst_i = 1'b0;
    r = cyc;
    step();
    total++; if (start_o !== 1'b1) begin bad++; $display("FAIL rmid_restart: got %b want 1 at cyc %0d", start_o, r + 1); end
    en_i = 1'b0;
    repeat (6) step();
    total++; if (obs_starts.size() !== nst + 1) begin bad++; $display("FAIL rmid_nstarts: got %0d want %0d", obs_starts.size(), nst + 1); end
    total++; if (cnt_o !== 12'd1) begin bad++; $display("FAIL rmid_post_cnt: got %0d want 1", cnt_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_post_busy: got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overrun();
    test_disable();
    test_timeout();
    test_spurious();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
